// File: rtl/drac_icache_miss_tracker.sv
// I$ miss tracker between the core refill port and the L1.5 adapter miss port.
// It holds one outstanding line refill at a time. Responses made stale by a core
// kill or by a matching invalidation are dropped. Invalidations are forwarded to
// the core one cycle later, and a sticky watchdog flags refills that never return.
//
//   state | meaning
//   IDLE  | no refill outstanding, accepting a core miss
//   REQ   | miss_valid_o held until the adapter accepts the line address
//   WAIT  | request accepted, waiting for the refill (watchdog counting)
module drac_icache_miss_tracker #(
  parameter int unsigned PAddrWidth    = 40,
  parameter int unsigned LineWidth     = 512,
  parameter int unsigned LineOffW      = 6,
  parameter int unsigned TimeoutCycles = 4096,
  parameter int unsigned CntWidth      = 13
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  core_req_valid_i,
  output logic                  core_req_ready_o,
  input  logic [PAddrWidth-1:0] core_req_paddr_i,
  input  logic                  core_kill_i,
  output logic                  core_resp_valid_o,
  output logic [LineWidth-1:0]  core_resp_data_o,
  output logic                  core_inval_valid_o,
  output logic [PAddrWidth-1:0] core_inval_addr_o,
  output logic                  miss_valid_o,
  input  logic                  miss_ready_i,
  output logic [PAddrWidth-1:0] miss_paddr_o,
  input  logic                  resp_valid_i,
  input  logic [LineWidth-1:0]  resp_data_i,
  input  logic                  inval_valid_i,
  input  logic [PAddrWidth-1:0] inval_addr_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [PAddrWidth-1:0] OffMask  = PAddrWidth'((64'd1 << LineOffW) - 64'd1);
  localparam logic [CntWidth-1:0]   CntLastM = CntWidth'(TimeoutCycles - 1);

  state_e                state_q;
  logic [PAddrWidth-1:0] line_q;
  logic                  drop_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  inval_hit;
  logic                  stale;

  // A kill or an invalidation of the pending line makes the refill unusable.
  assign inval_hit = inval_valid_i &&
                     (inval_addr_i[PAddrWidth-1:LineOffW] == line_q[PAddrWidth-1:LineOffW]);
  assign stale     = core_kill_i | inval_hit;

  assign core_req_ready_o = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign miss_valid_o     = (state_q == REQ);
  assign miss_paddr_o     = line_q;

  // Tracker FSM, drop flag, watchdog, and registered core-facing outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q            <= IDLE;
      line_q             <= '0;
      drop_q             <= 1'b0;
      cnt_q              <= '0;
      timeout_o          <= 1'b0;
      core_resp_valid_o  <= 1'b0;
      core_resp_data_o   <= '0;
      core_inval_valid_o <= 1'b0;
      core_inval_addr_o  <= '0;
    end else begin
      core_resp_valid_o  <= 1'b0;
      core_inval_valid_o <= inval_valid_i;
      if (inval_valid_i) begin
        core_inval_addr_o <= inval_addr_i;
      end
      case (state_q)
        IDLE: begin
          if (core_req_valid_i) begin
            line_q  <= core_req_paddr_i & ~OffMask;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // The request is still issued when stale; only its response is dropped.
          if (stale) begin
            drop_q <= 1'b1;
          end
          if (miss_ready_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (resp_valid_i) begin
            if (!(drop_q || stale)) begin
              core_resp_valid_o <= 1'b1;
              core_resp_data_o  <= resp_data_i;
            end
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            if (stale) begin
              drop_q <= 1'b1;
            end
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CntWidth'(1);
            end
            // Flag raised on the edge where the counter reaches TimeoutCycles.
            if (cnt_q == CntLastM) begin
              timeout_o <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drac_icache_miss_tracker.sv
// Self-checking bench for drac_icache_miss_tracker: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level reference.
module tb_drac_icache_miss_tracker;

  localparam int PAW = 40;
  localparam int LW  = 512;
  localparam int TO  = 16;

  logic           clk_i = 1'b0;
  logic           rstn_i;
  logic           core_req_valid_i;
  logic           core_req_ready_o;
  logic [PAW-1:0] core_req_paddr_i;
  logic           core_kill_i;
  logic           core_resp_valid_o;
  logic [LW-1:0]  core_resp_data_o;
  logic           core_inval_valid_o;
  logic [PAW-1:0] core_inval_addr_o;
  logic           miss_valid_o;
  logic           miss_ready_i;
  logic [PAW-1:0] miss_paddr_o;
  logic           resp_valid_i;
  logic [LW-1:0]  resp_data_i;
  logic           inval_valid_i;
  logic [PAW-1:0] inval_addr_i;
  logic           busy_o;
  logic           timeout_o;

  drac_icache_miss_tracker #(
    .PAddrWidth(PAW), .LineWidth(LW), .LineOffW(6), .TimeoutCycles(TO), .CntWidth(13)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_paddr_i(core_req_paddr_i), .core_kill_i(core_kill_i),
    .core_resp_valid_o(core_resp_valid_o), .core_resp_data_o(core_resp_data_o),
    .core_inval_valid_o(core_inval_valid_o), .core_inval_addr_o(core_inval_addr_o),
    .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i), .miss_paddr_o(miss_paddr_o),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .inval_valid_i(inval_valid_i), .inval_addr_i(inval_addr_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: one refill "transaction" tracked as plain flags and a wait count.
  bit             m_pending, m_issued, m_drop, m_timeout, m_resp_v, m_inval_v;
  int             m_waits;
  logic [PAW-1:0] m_line, m_inval_addr;
  logic [LW-1:0]  m_resp_data;

  task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_update();
    bit hit;
    m_resp_v = 1'b0;
    if (!rstn_i) begin
      m_pending = 0; m_issued = 0; m_drop = 0; m_timeout = 0; m_inval_v = 0;
      m_waits = 0; m_line = '0; m_inval_addr = '0; m_resp_data = '0;
      return;
    end
    m_inval_v = inval_valid_i;
    if (inval_valid_i) m_inval_addr = inval_addr_i;
    hit = core_kill_i || (inval_valid_i && ((inval_addr_i >> 6) == (m_line >> 6)));
    if (!m_pending) begin
      if (core_req_valid_i) begin
        m_pending = 1; m_issued = 0; m_drop = 0; m_waits = 0;
        m_line = core_req_paddr_i & ~40'h3f;
      end
    end else if (!m_issued) begin
      if (hit) m_drop = 1;
      if (miss_ready_i) m_issued = 1;
    end else if (resp_valid_i) begin
      if (!(m_drop || hit)) begin
        m_resp_v = 1; m_resp_data = resp_data_i;
      end
      m_pending = 0;
    end else begin
      if (hit) m_drop = 1;
      m_waits++;
      if (m_waits == TO) m_timeout = 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("ready",      core_req_ready_o,   !m_pending);
    check_eq("busy",       busy_o,             m_pending);
    check_eq("miss_valid", miss_valid_o,       m_pending && !m_issued);
    check_eq("miss_paddr", miss_paddr_o,       m_line);
    check_eq("resp_valid", core_resp_valid_o,  m_resp_v);
    check_eq("resp_data",  core_resp_data_o,   m_resp_data);
    check_eq("inval_v",    core_inval_valid_o, m_inval_v);
    check_eq("inval_addr", core_inval_addr_o,  m_inval_addr);
    check_eq("timeout",    timeout_o,          m_timeout);
  endtask

  // One clock: reference consumes this cycle's inputs, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk_i);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic clear_in();
    rstn_i = 1; core_req_valid_i = 0; core_req_paddr_i = '0; core_kill_i = 0;
    miss_ready_i = 0; resp_valid_i = 0; resp_data_i = '0;
    inval_valid_i = 0; inval_addr_i = '0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Issue a miss and complete the handshake immediately; leaves the tracker in WAIT.
  task automatic req_and_issue(input logic [PAW-1:0] pa);
    core_req_valid_i = 1; core_req_paddr_i = pa; step(); core_req_valid_i = 0;
    miss_ready_i = 1; step(); miss_ready_i = 0;
  endtask

  task automatic respond(input logic [LW-1:0] d);
    resp_valid_i = 1; resp_data_i = d; step(); resp_valid_i = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] d;
    clear_in();
    rstn_i = 0; step(); step();
    check_eq("rst_ready", core_req_ready_o, 1);
    check_eq("rst_miss_valid", miss_valid_o, 0);
    rstn_i = 1;

    // Basic refill
    d = rand_line();
    core_req_valid_i = 1; core_req_paddr_i = 40'h80001234; step(); core_req_valid_i = 0;
    check_eq("basic_mvalid", miss_valid_o, 1);
    check_eq("basic_paddr", miss_paddr_o, 40'h80001200);
    miss_ready_i = 1; step(); miss_ready_i = 0;
    repeat (4) step();
    respond(d);
    check_eq("basic_resp_v", core_resp_valid_o, 1);
    check_eq("basic_resp_d", core_resp_data_o, d);
    check_eq("basic_ready", core_req_ready_o, 1);
    step();
    check_eq("basic_pulse", core_resp_valid_o, 0);

    // Backpressure with an ignored second request
    core_req_valid_i = 1; core_req_paddr_i = 40'h12345678c7; step(); core_req_valid_i = 0;
    for (int i = 0; i < 7; i++) begin
      check_eq("bp_mvalid", miss_valid_o, 1);
      check_eq("bp_paddr", miss_paddr_o, 40'h12345678c0);
      if (i == 3) begin core_req_valid_i = 1; core_req_paddr_i = 40'h00abcdef00; end
      step();
      core_req_valid_i = 0;
    end
    check_eq("bp_held", miss_valid_o, 1);
    miss_ready_i = 1; step(); miss_ready_i = 0;
    check_eq("bp_one_hs", miss_valid_o, 0);
    check_eq("bp_busy", busy_o, 1);
    d = rand_line(); respond(d);
    check_eq("bp_resp_v", core_resp_valid_o, 1);

    // Kill in WAIT, then kill together with the response
    req_and_issue(40'h0000400040); step();
    core_kill_i = 1; step(); core_kill_i = 0; step();
    respond(rand_line());
    check_eq("kill_wait_resp", core_resp_valid_o, 0);
    check_eq("kill_wait_busy", busy_o, 0);
    req_and_issue(40'h0000400080); step();
    core_kill_i = 1; respond(rand_line()); core_kill_i = 0;
    check_eq("kill_same_resp", core_resp_valid_o, 0);
    check_eq("kill_same_busy", busy_o, 0);

    // Invalidation of a neighbouring line, then of the pending line
    req_and_issue(40'h80001234);
    inval_valid_i = 1; inval_addr_i = 40'h80001240; step(); inval_valid_i = 0;
    check_eq("inval1_fwd_v", core_inval_valid_o, 1);
    check_eq("inval1_fwd_a", core_inval_addr_o, 40'h80001240);
    respond(rand_line());
    check_eq("inval1_resp", core_resp_valid_o, 1);
    req_and_issue(40'h80001234);
    inval_valid_i = 1; inval_addr_i = 40'h80001200; step(); inval_valid_i = 0;
    check_eq("inval2_fwd_v", core_inval_valid_o, 1);
    check_eq("inval2_fwd_a", core_inval_addr_o, 40'h80001200);
    respond(rand_line());
    check_eq("inval2_resp", core_resp_valid_o, 0);

    // Watchdog: exactly TO wait cycles, survives a late response, cleared by reset
    req_and_issue(40'h0000abc000);
    for (int i = 1; i <= TO; i++) begin
      step();
      check_eq("wd_edge", timeout_o, (i >= TO) ? 1'b1 : 1'b0);
    end
    repeat (3) step();
    d = rand_line(); respond(d);
    check_eq("wd_late_resp", core_resp_valid_o, 1);
    check_eq("wd_sticky", timeout_o, 1);
    step();
    check_eq("wd_sticky2", timeout_o, 1);
    rstn_i = 0; step(); rstn_i = 1;
    check_eq("wd_cleared", timeout_o, 0);

    // Reset mid-WAIT, then a stray response
    req_and_issue(40'h0000def000); step();
    rstn_i = 0; step(); rstn_i = 1;
    check_eq("rstw_busy", busy_o, 0);
    check_eq("rstw_paddr", miss_paddr_o, 0);
    check_eq("rstw_ready", core_req_ready_o, 1);
    respond(rand_line());
    check_eq("rstw_stray", core_resp_valid_o, 0);
    check_eq("rstw_ready2", core_req_ready_o, 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rstn_i           = ($urandom_range(0, 199) != 0);
      core_req_valid_i = ($urandom_range(0, 9) < 3);
      core_req_paddr_i = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) core_req_paddr_i[PAW-1:8] = 32'h80001;
      core_kill_i      = ($urandom_range(0, 29) == 0);
      miss_ready_i     = ($urandom_range(0, 1) == 1);
      resp_valid_i     = ($urandom_range(0, 11) == 0);
      resp_data_i      = rand_line();
      inval_valid_i    = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       inval_addr_i = m_line | 40'($urandom_range(0, 63));
        1:       inval_addr_i = m_line + 40'd64;
        default: inval_addr_i = {8'($urandom), 32'($urandom)};
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
